// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency (2-cycle) ALU between two requesters.
// Grants are combinational, results are routed back by a tag pipeline, and completions are counted.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [7:0]       done_cnt0,
  output logic [7:0]       done_cnt1
);

  logic       prio;
  logic       grant_any;
  logic       grant_idx;
  logic       tag0_valid;
  logic       tag0_idx;
  logic       tag1_valid;
  logic       tag1_idx;
  logic       rsp_any;
  logic       err;
  logic [1:0] outstanding;

  // Grant decision; reset and hold both suppress any grant in the current cycle.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (!rst && !hold) begin
      unique case (req_valid)
        2'b01: begin
          grant_any = 1'b1;
          grant_idx = 1'b0;
        end
        2'b10: begin
          grant_any = 1'b1;
          grant_idx = 1'b1;
        end
        2'b11: begin
          grant_any = 1'b1;
          grant_idx = prio;
        end
        default: begin
          grant_any = 1'b0;
          grant_idx = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    req_ready    = 2'b00;
    alu_in_valid = grant_any;
    alu_op       = 2'b00;
    alu_a        = '0;
    alu_b        = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      if (grant_idx) begin
        alu_op = req1_op;
        alu_a  = req1_a;
        alu_b  = req1_b;
      end else begin
        alu_op = req0_op;
        alu_a  = req0_a;
        alu_b  = req0_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant_any) begin
      prio <= ~grant_idx;
    end
  end

  // Tag pipeline mirrors the ALU latency so tag1 lines up with alu_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag0_valid <= 1'b0;
      tag0_idx   <= 1'b0;
      tag1_valid <= 1'b0;
      tag1_idx   <= 1'b0;
    end else begin
      tag0_valid <= grant_any;
      tag0_idx   <= grant_idx;
      tag1_valid <= tag0_valid;
      tag1_idx   <= tag0_idx;
    end
  end

  assign rsp_any = !rst && tag1_valid && alu_out_valid;

  always_comb begin
    rsp_valid = 2'b00;
    if (rsp_any) begin
      rsp_valid[tag1_idx] = 1'b1;
    end
  end

  assign rsp_data = rst ? '0 : alu_out;

  // A result arriving without a tag, or a tag without a result, means the ALU broke its latency contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (tag1_valid != alu_out_valid) begin
      err <= 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 2'd0;
    end else if (grant_any && !rsp_any) begin
      outstanding <= outstanding + 2'd1;
    end else if (!grant_any && rsp_any && outstanding != 2'd0) begin
      outstanding <= outstanding - 2'd1;
    end
  end

  assign busy = (outstanding != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt0 <= 8'd0;
      done_cnt1 <= 8'd0;
    end else begin
      if (rsp_valid[0] && done_cnt0 != 8'hFF) begin
        done_cnt0 <= done_cnt0 + 8'd1;
      end
      if (rsp_valid[1] && done_cnt1 != 8'hFF) begin
        done_cnt1 <= done_cnt1 + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural 2-cycle ALU plus a round-robin reference model.
module tb_alu_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hold = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [1:0]   req0_op = 2'b00;
  logic [1:0]   req1_op = 2'b00;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_in_valid;
  logic [W-1:0] alu_out;
  logic         alu_out_valid;
  logic [1:0]   rsp_valid;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic [7:0]   done_cnt0;
  logic [7:0]   done_cnt1;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prio_m = 0;
  int   done0_m = 0;
  int   done1_m = 0;

  logic         s1_v, s2_v;
  logic [W-1:0] s1_d, s2_d;
  exp_t         me;
  int           pend;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] aluFn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return '0;
    endcase
  endfunction

  // Shared ALU stand-in: two-cycle latency, cleared by the system reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s1_d <= '0; s2_v <= 1'b0; s2_d <= '0;
    end else begin
      s1_v <= alu_in_valid;
      s1_d <= aluFn(alu_op, alu_a, alu_b);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end
  assign alu_out       = s2_d;
  assign alu_out_valid = s2_v;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the expected grant comes from the round-robin rule.
  task automatic applyStimulus(input logic [1:0] v, input logic h,
                               input logic [1:0] op0, input logic [1:0] op1,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1);
    int   g;
    exp_t e;
    @(negedge clk);
    req_valid = v; hold = h;
    req0_op = op0; req1_op = op1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    g = -1;
    if (!h) begin
      if (v == 2'b11) g = prio_m;
      else if (v[0]) g = 0;
      else if (v[1]) g = 1;
    end
    checkOutput("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
    checkOutput("alu_in_valid", 32'(alu_in_valid), (g >= 0) ? 1 : 0);
    if (g >= 0) begin
      checkOutput("alu_op", 32'(alu_op), 32'((g == 0) ? op0 : op1));
      checkOutput("alu_a", 32'(alu_a), 32'((g == 0) ? a0 : a1));
      checkOutput("alu_b", 32'(alu_b), 32'((g == 0) ? b0 : b1));
      e.idx  = g;
      e.data = (g == 0) ? aluFn(op0, a0, b0) : aluFn(op1, a1, b1);
      e.due  = cyc + 2;
      sb.push_back(e);
      prio_m = 1 - g;
    end else begin
      checkOutput("alu_idle", 32'({alu_op, alu_a, alu_b}), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic randomOp(input logic [1:0] v, input logic h);
    applyStimulus(v, h, 2'($urandom), 2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  // Asserts reset inside the current cycle, so anything already in flight is dropped.
  task automatic resetDut();
    #2;
    rst = 1'b1;
    req_valid = 2'b00; hold = 1'b0;
    sb.delete();
    prio_m = 0; done0_m = 0; done1_m = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a response appears, and tracks busy/counters.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      pend = 0;
      foreach (sb[i]) if (sb[i].due <= cyc + 1) pend++;
      checkOutput("busy", 32'(busy), (pend != 0) ? 1 : 0);
      checkOutput("done_cnt0", 32'(done_cnt0), done0_m);
      checkOutput("done_cnt1", 32'(done_cnt1), done1_m);
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          me = sb.pop_front();
          checkOutput("rsp_valid", 32'(rsp_valid), 1 << me.idx);
          checkOutput("rsp_data", 32'(rsp_data), 32'(me.data));
          checkOutput("rsp_cycle", cyc, me.due);
          if (me.idx == 0 && done0_m < 255) done0_m++;
          if (me.idx == 1 && done1_m < 255) done1_m++;
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        me = sb.pop_front();
        checkOutput("rsp_missing", 32'(rsp_valid), 1 << me.idx);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    req_valid = 2'b11; req0_op = 2'b01; req0_a = 4'd3; req0_b = 4'd4;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_alu_in_valid", 32'(alu_in_valid), 0);
    checkOutput("rst_alu_bus", 32'({alu_op, alu_a, alu_b}), 0);
    checkOutput("rst_rsp", 32'({rsp_valid, rsp_data}), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'({done_cnt0, done_cnt1}), 0);
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester add right after reset.
    applyStimulus(2'b01, 1'b0, 2'b01, 2'b00, 4'd3, 4'd4, 4'd0, 4'd0);
    idle(3);
    checkOutput("done_cnt0_single", 32'(done_cnt0), 1);

    // Subtraction wrap on requester 1.
    applyStimulus(2'b10, 1'b0, 2'b00, 2'b10, 4'd0, 4'd0, 4'd2, 4'd5);
    idle(3);

    // Contention from a fresh pointer.
    resetDut();
    for (int i = 0; i < 8; i++) randomOp(2'b11, 1'b0);
    idle(3);

    // Hold with both valid while one op is in flight.
    randomOp(2'b01, 1'b0);
    for (int i = 0; i < 4; i++) randomOp(2'b11, 1'b1);
    checkOutput("hold_busy_low", 32'(busy), 0);
    idle(2);

    // Reset in the cycle of the second grant.
    randomOp(2'b01, 1'b0);
    randomOp(2'b10, 1'b0);
    resetDut();
    idle(4);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_done0", 32'(done_cnt0), 0);
    checkOutput("midrst_done1", 32'(done_cnt1), 0);

    // Random traffic including hold and the pass-through ops.
    for (int i = 0; i < 300; i++) randomOp(2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
    idle(4);

    // Saturation of done_cnt0.
    resetDut();
    for (int i = 0; i < 262; i++) randomOp(2'b01, 1'b0);
    idle(4);
    checkOutput("done_cnt0_sat", 32'(done_cnt0), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the operand/result width, matching the shared ALU.
REQ-002 SHALL have input clk, 1 bit, the clock; reset is rst, asynchronous, active-high.
REQ-003 SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have input hold, 1 bit; when high, no new grants are issued.
REQ-005 SHALL have input req_valid, 2 bits, request valid per requester (index 0, 1).
REQ-006 SHALL have output req_ready, 2 bits, grant per requester; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 SHALL have inputs req0_op and req1_op (2 bits each), req0_a, req0_b, req1_a and req1_b (WIDTH each): the per-requester operation and operands.
REQ-008 SHALL have outputs alu_op (2), alu_a (WIDTH), alu_b (WIDTH) and alu_in_valid (1), which drive the shared ALU inputs.
REQ-009 SHALL have inputs alu_out (WIDTH) and alu_out_valid (1), the shared ALU result; the ALU has a fixed 2-cycle latency and no stall.
REQ-010 SHALL have output rsp_valid, 2 bits, the per-requester result strobe.
REQ-011 SHALL have output rsp_data, WIDTH bits, equal to alu_out, shared by both requesters.
REQ-012 SHALL have output busy, 1 bit, high while any accepted operation has not yet been returned.
REQ-013 SHALL have outputs done_cnt0 and done_cnt1, 8 bits each, saturating per-requester completion counters.

Function
REQ-014 SHALL compute grants combinationally: with hold low, at most one req_ready bit is high, and only for a requester whose req_valid is high.
REQ-015 SHALL arbitrate round-robin using a priority pointer prio (1 bit).
- Both valid: grant requester prio.
- One valid: grant that requester.
REQ-016 SHALL set prio, after every grant, to the index not granted; prio SHALL be unchanged in cycles with no grant.
REQ-017 SHALL assert alu_in_valid in exactly the grant cycle, with alu_op, alu_a and alu_b taken from the granted requester.
REQ-018 SHALL drive alu_op, alu_a and alu_b to 0 when there is no grant.
REQ-019 SHALL carry the granted index and a valid bit through a 2-stage tag pipeline (tag0, tag1) aligned to the ALU latency.
REQ-020 SHALL time the response as follows: for a grant in cycle t, rsp_valid[tag] is high in cycle t+2 only, and rsp_data equals alu_out in that cycle.
REQ-021 SHALL keep rsp_valid zero unless both the tag1 valid bit and alu_out_valid are high.
REQ-022 SHALL treat a tag1 valid bit that does not match alu_out_valid as a protocol error; rsp_valid SHALL then be 0 and a sticky internal flag err SHALL set.
REQ-023 SHALL keep an outstanding counter, 2 bits, range 0..2: +1 on a grant, -1 on a response, unchanged when both occur in the same cycle.
REQ-024 SHALL drive busy = (outstanding != 0).
REQ-025 SHALL allow back-to-back grants every cycle; throughput is 1 op/cycle, with no bubbles.
REQ-026 SHALL keep grants independent of responses, since no backpressure exists on responses.
REQ-027 SHALL increment done_cntN on each rsp_valid[N], holding the count at 255 once reached.
REQ-028 SHALL apply hold from the same cycle, with no grant that cycle; operations already in flight SHALL still complete normally.
REQ-029 SHALL pass op values 00 and 11 through unchanged; they complete normally, return result 0, and are counted.

Reset
REQ-030 SHALL, on rst high, asynchronously clear prio (to 0), the tag pipeline, outstanding, err, done_cnt0 and done_cnt1.
REQ-031 SHALL hold all outputs at 0 during reset; req_ready SHALL be 0 while rst is high.
REQ-032 SHALL discard in-flight operations on reset mid-operation, with no rsp_valid after rst deasserts.
REQ-033 SHALL grant in the first cycle after rst deasserts, with prio = 0.

Verification
REQ-034 SHALL cover the single-requester case: req0 op=01, a=3, b=4 in cycle t -> rsp_valid=01 and rsp_data=7 in t+2; done_cnt0=1.
REQ-035 SHALL cover contention: both requesters valid continuously -> grants alternate 0,1,0,1; responses alternate with 2-cycle lag; busy stays high.
REQ-036 SHALL cover subtraction wrap: req1 op=10, a=2, b=5 (WIDTH=4) -> rsp_valid=10, rsp_data=4'hD.
REQ-037 SHALL cover hold: hold high with both valid -> req_ready=00 and alu_in_valid=0; an in-flight result is still returned; busy falls 2 cycles after the last grant.
REQ-038 SHALL cover reset mid-operation: grants in t and t+1, rst pulsed in t+1 -> no rsp_valid afterward; outstanding=0, done counters=0.
REQ-039 SHALL cover saturation: 260 completions for req0 -> done_cnt0=255.
